// File: rtl/chroma_dma_sequencer.sv
// Splits a chroma conversion job into <=CHUNK_BYTES bursts and issues paired read/write mover requests per chunk.
// Next chunk issues 1 cycle after its predecessor's last output beat; requests hold until each mover accepts.
module chroma_dma_sequencer #(
    parameter int ADDR_WIDTH  = 64,
    parameter int LEN_WIDTH   = 32,
    parameter int CHUNK_BYTES = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_src,
    input  logic [ADDR_WIDTH-1:0] cmd_dst,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [ADDR_WIDTH-1:0] rd_src,
    output logic [ADDR_WIDTH-1:0] rd_len,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [ADDR_WIDTH-1:0] wr_dest,
    input  logic                  out_beat,
    output logic                  busy,
    output logic                  done,
    output logic                  err_overrun
);
    localparam int CNT_W = $clog2(CHUNK_BYTES / 4 + 1);
    localparam logic [LEN_WIDTH-1:0] CHUNK_L = LEN_WIDTH'(CHUNK_BYTES);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] src, dst, src_nxt, dst_nxt;
    logic [LEN_WIDTH-1:0]  remaining, chunk_len, cmd_len_al, rem_after, next_chunk;
    logic [CNT_W-1:0]      count, count_nxt, expected;
    logic                  accept, chunk_end, in_chunk, beat_ok, overrun_beat, reqs_done;

    function automatic logic [LEN_WIDTH-1:0] clip(input logic [LEN_WIDTH-1:0] r);
        return (r > CHUNK_L) ? CHUNK_L : r;
    endfunction

    // Low 3 length bits are dropped: the movers only handle whole 8-byte words.
    assign cmd_len_al = cmd_len & ~LEN_WIDTH'(7);
    assign rem_after  = remaining - chunk_len;
    assign next_chunk = clip(rem_after);
    assign src_nxt    = src + ADDR_WIDTH'(chunk_len);
    assign dst_nxt    = dst + (ADDR_WIDTH'(chunk_len) << 1);
    // Each 8-byte 4:2:2 input word expands to two 8-byte 4:4:4 output words.
    assign expected   = CNT_W'(chunk_len >> 2);

    assign busy = (state == ISSUE) || (state == WAIT);
    assign done = (state == FINISH);

    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        chunk_end    = 1'b0;
        cmd_ready    = (state == IDLE);
        in_chunk     = (state == ISSUE) || (state == WAIT);
        beat_ok      = out_beat && in_chunk && (count != expected);
        overrun_beat = out_beat && !beat_ok;
        count_nxt    = count + CNT_W'(beat_ok);
        reqs_done    = (!rd_valid || rd_ready) && (!wr_valid || wr_ready);
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = (cmd_len_al == '0) ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
                if (reqs_done) begin
                    if (count_nxt == expected) chunk_end = 1'b1;
                    else                       state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (count_nxt == expected) chunk_end = 1'b1;
            end
            FINISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (chunk_end) state_nxt = (rem_after != '0) ? ISSUE : FINISH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            src         <= '0;
            dst         <= '0;
            remaining   <= '0;
            chunk_len   <= '0;
            count       <= '0;
            err_overrun <= 1'b0;
            rd_valid    <= 1'b0;
            wr_valid    <= 1'b0;
            rd_src      <= '0;
            rd_len      <= '0;
            wr_dest     <= '0;
        end else begin
            state <= state_nxt;
            count <= chunk_end ? '0 : count_nxt;

            if (accept)            err_overrun <= 1'b0;
            else if (overrun_beat) err_overrun <= 1'b1;

            if (accept) begin
                src       <= cmd_src;
                dst       <= cmd_dst;
                remaining <= cmd_len_al;
                chunk_len <= clip(cmd_len_al);
                count     <= '0;
            end else if (chunk_end) begin
                src       <= src_nxt;
                dst       <= dst_nxt;
                remaining <= rem_after;
                chunk_len <= next_chunk;
            end

            // Request outputs only change when a new chunk is launched, so they stay stable while valid.
            if (accept && (cmd_len_al != '0)) begin
                rd_valid <= 1'b1;
                wr_valid <= 1'b1;
                rd_src   <= cmd_src;
                rd_len   <= ADDR_WIDTH'(clip(cmd_len_al));
                wr_dest  <= cmd_dst;
            end else if (chunk_end && (rem_after != '0)) begin
                rd_valid <= 1'b1;
                wr_valid <= 1'b1;
                rd_src   <= src_nxt;
                rd_len   <= ADDR_WIDTH'(next_chunk);
                wr_dest  <= dst_nxt;
            end else begin
                if (rd_ready) rd_valid <= 1'b0;
                if (wr_ready) wr_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_chroma_dma_sequencer.sv
// Bench for chroma_dma_sequencer: table of jobs plus random jobs against a chunk-list reference model.
module tb_chroma_dma_sequencer;
    localparam int CB = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [63:0] cmd_src, cmd_dst;
    logic [31:0] cmd_len;
    logic        rd_valid, rd_ready, wr_valid, wr_ready;
    logic [63:0] rd_src, rd_len, wr_dest;
    logic        out_beat, busy, done, err_overrun;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [63:0] exp_src[$];
    logic [63:0] exp_len[$];
    logic [63:0] exp_dst[$];

    typedef struct {
        logic [63:0] src;
        logic [63:0] dst;
        logic [31:0] len;
        int          mode;
        int          n_chunks;
        logic [63:0] last_src;
        logic [63:0] last_len;
        logic [63:0] last_dst;
    } vec_t;

    chroma_dma_sequencer #(.ADDR_WIDTH(64), .LEN_WIDTH(32), .CHUNK_BYTES(CB)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_src(rd_src), .rd_len(rd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_dest(wr_dest),
        .out_beat(out_beat), .busy(busy), .done(done), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: the job is a list of chunks at byte offsets 0, CB, 2*CB ... of the truncated length.
    function automatic void build(input logic [63:0] s, input logic [63:0] d, input logic [31:0] l);
        longint lt, n;
        exp_src.delete();
        exp_len.delete();
        exp_dst.delete();
        lt = longint'(l) / 8 * 8;
        for (longint off = 0; off < lt; off += CB) begin
            n = (lt - off > CB) ? CB : lt - off;
            exp_src.push_back(s + 64'(off));
            exp_len.push_back(64'(n));
            exp_dst.push_back(d + 64'(2 * off));
        end
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_wr_valid"}, wr_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err_overrun"}, err_overrun, 0);
        chk({tag, "_rd_src"}, rd_src, 0);
        chk({tag, "_rd_len"}, rd_len, 0);
        chk({tag, "_wr_dest"}, wr_dest, 0);
    endtask

    // mode 0: movers always ready; 1: random readies/beats; 2: rd_ready low for 5 cycles after accept.
    task automatic run_job(input logic [63:0] src, input logic [63:0] dst, input logic [31:0] len,
                           input int mode, input int extra, input int abort_at,
                           output int n_rd, output logic [63:0] l_src, output logic [63:0] l_len,
                           output logic [63:0] l_dst);
        int pending, sent, total, acc, last_evt, rel, n_wr, nch;
        bit got_done, ovr, prev_stall, busy_bad, any_valid;
        logic [63:0] p_src, p_len;
        logic [63:0] wl[$];
        build(src, dst, len);
        nch = exp_src.size();
        total = 0;
        foreach (exp_len[i]) begin
            total += int'(exp_len[i] >> 2);
            wl.push_back(exp_len[i]);
        end
        n_rd = 0; n_wr = 0; pending = 0; sent = 0; last_evt = 0;
        got_done = 0; ovr = 0; prev_stall = 0; busy_bad = 0; any_valid = 0;
        l_src = 0; l_len = 0; l_dst = 0; p_src = 0; p_len = 0;

        @(posedge clk); #1;
        cmd_valid = 1; cmd_src = src; cmd_dst = dst; cmd_len = len;
        @(negedge clk);
        chk("cmd_ready_at_accept", cmd_ready, 1);
        acc = cyc;
        for (int k = 0; k < 3000 && !got_done; k++) begin
            @(posedge clk); #1;
            cmd_valid = 0;
            cmd_src = {$urandom, $urandom};
            cmd_dst = {$urandom, $urandom};
            cmd_len = $urandom;
            rel = cyc - acc;
            case (mode)
                0: begin rd_ready = 1; wr_ready = 1; out_beat = (pending > 0); end
                1: begin
                    rd_ready = 1'($urandom_range(0, 1));
                    wr_ready = 1'($urandom_range(0, 1));
                    out_beat = (pending > 0) && ($urandom_range(0, 3) != 0);
                end
                default: begin rd_ready = (rel > 5); wr_ready = 1; out_beat = (pending > 0); end
            endcase
            @(negedge clk);
            if (rel == 1) begin
                chk("err_clear_on_accept", err_overrun, 0);
                if (total > 0) begin
                    chk("busy_after_accept", busy, 1);
                    chk("rd_valid_after_accept", rd_valid, 1);
                    chk("wr_valid_after_accept", wr_valid, 1);
                end
            end
            if (mode == 2 && rel == 2) begin
                chk("wr_valid_dropped", wr_valid, 0);
                chk("rd_valid_held", rd_valid, 1);
            end
            if (prev_stall) begin
                chk("rd_valid_hold", rd_valid, 1);
                chk("rd_src_hold", rd_src, p_src);
                chk("rd_len_hold", rd_len, p_len);
            end
            prev_stall = rd_valid && !rd_ready;
            p_src = rd_src;
            p_len = rd_len;
            if (rd_valid || wr_valid) any_valid = 1;
            if (total > 0 && !done && !busy) busy_bad = 1;
            if (err_overrun && extra == 0) ovr = 1;
            if (rd_valid && rd_ready) begin
                n_rd++; l_src = rd_src; l_len = rd_len;
                if (cyc > last_evt) last_evt = cyc;
                if (exp_src.size() == 0) chk("rd_unexpected_req", 1, 0);
                else begin
                    chk("rd_src", rd_src, exp_src.pop_front());
                    chk("rd_len", rd_len, exp_len.pop_front());
                end
            end
            if (wr_valid && wr_ready) begin
                n_wr++; l_dst = wr_dest;
                if (cyc > last_evt) last_evt = cyc;
                if (exp_dst.size() == 0) chk("wr_unexpected_req", 1, 0);
                else begin
                    chk("wr_dest", wr_dest, exp_dst.pop_front());
                    pending += int'(wl.pop_front() >> 2);
                end
                if (n_wr == 1) pending += extra;
            end
            if (out_beat) begin
                pending--; sent++;
                if (sent <= total) last_evt = cyc;
            end
            if (abort_at > 0 && sent == abort_at) return;
            if (done) begin
                got_done = 1;
                chk("done_cycle", 64'(cyc), 64'(total == 0 ? acc + 1 : last_evt + 1));
                chk("busy_at_done", busy, 0);
                chk("beats_sent", 64'(sent), 64'(total + extra));
                chk("rd_req_count", 64'(n_rd), 64'(nch));
                chk("wr_req_count", 64'(n_wr), 64'(nch));
                chk("any_valid", any_valid, (total > 0));
            end
        end
        if (!got_done) begin
            checks++; errors++;
            $display("FAIL done_timeout: no done within budget (len %0d)", len);
        end else begin
            @(posedge clk); #1;
            out_beat = 0; rd_ready = 0; wr_ready = 0;
            @(negedge clk);
            chk("done_single_pulse", done, 0);
            chk("cmd_ready_after_done", cmd_ready, 1);
            chk("err_overrun_after_job", err_overrun, (extra > 0));
            chk("no_overrun_during_job", ovr, 0);
            chk("busy_throughout_job", busy_bad, 0);
        end
    endtask

    initial begin
        vec_t vecs[6];
        int n_rd;
        logic [63:0] l_src, l_len, l_dst, rs, rdst;
        logic [31:0] rl;

        vecs[0] = '{64'h0,    64'h8,    32'd128, 0, 1, 64'h0,    64'd128, 64'h8};
        vecs[1] = '{64'h1000, 64'h8000, 32'd296, 0, 3, 64'h1100, 64'd40,  64'h8200};
        vecs[2] = '{64'h2000, 64'h9000, 32'd128, 2, 1, 64'h2000, 64'd128, 64'h9000};
        vecs[3] = '{64'h40,   64'h80,   32'd0,   0, 0, 64'h0,    64'h0,   64'h0};
        vecs[4] = '{64'h100,  64'h200,  32'd13,  1, 1, 64'h100,  64'd8,   64'h200};
        vecs[5] = '{64'h3000, 64'hA000, 32'd520, 1, 5, 64'h3200, 64'd8,   64'hA400};

        rst = 1; cmd_valid = 0; cmd_src = 0; cmd_dst = 0; cmd_len = 0;
        rd_ready = 0; wr_ready = 0; out_beat = 0;
        repeat (2) @(negedge clk);
        check_reset("reset");
        @(posedge clk); #1;
        rst = 0;

        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].mode, 0, 0, n_rd, l_src, l_len, l_dst);
            chk($sformatf("vec%0d_chunks", i), 64'(n_rd), 64'(vecs[i].n_chunks));
            if (vecs[i].n_chunks > 0) begin
                chk($sformatf("vec%0d_last_src", i), l_src, vecs[i].last_src);
                chk($sformatf("vec%0d_last_len", i), l_len, vecs[i].last_len);
                chk($sformatf("vec%0d_last_dest", i), l_dst, vecs[i].last_dst);
            end
        end

        // Stray beat while idle sets the sticky flag.
        @(posedge clk); #1; out_beat = 1;
        @(posedge clk); #1; out_beat = 0;
        @(negedge clk);
        chk("overrun_idle_beat", err_overrun, 1);
        repeat (3) @(negedge clk);
        chk("overrun_sticky", err_overrun, 1);

        // 33rd beat on a 128-byte job; the flag is cleared at accept and set again by the extra beat.
        run_job(64'h0, 64'h8, 32'd128, 0, 1, 0, n_rd, l_src, l_len, l_dst);
        repeat (2) @(negedge clk);
        chk("overrun_extra_sticky", err_overrun, 1);

        // Reset in the middle of a 256-byte job, then a clean job afterwards.
        run_job(64'h5000, 64'hC000, 32'd256, 0, 0, 10, n_rd, l_src, l_len, l_dst);
        @(posedge clk); #1;
        rst = 1; out_beat = 0; rd_ready = 0; wr_ready = 0;
        #1;
        check_reset("midjob_reset");
        @(posedge clk); #1;
        rst = 0;
        run_job(64'h6000, 64'hD000, 32'd128, 0, 0, 0, n_rd, l_src, l_len, l_dst);
        chk("post_reset_chunks", 64'(n_rd), 64'd1);
        chk("post_reset_src", l_src, 64'h6000);
        chk("post_reset_dest", l_dst, 64'hD000);

        for (int r = 0; r < 6; r++) begin
            rs   = 64'($urandom_range(0, 1 << 20)) << 3;
            rdst = 64'($urandom_range(0, 1 << 20)) << 3;
            rl   = 32'($urandom_range(0, 700));
            run_job(rs, rdst, rl, 1, 0, 0, n_rd, l_src, l_len, l_dst);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
